// File: rtl/mole_spawner.sv
// Game-control stage: runs a timed game and issues one-cycle LED spawn requests.
// Optional SPAWN_SPEEDUP_EN shortens the spawn interval on every second tick.
module mole_spawner #(
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          SPAWN_MS     = 1000,
    parameter int          GAME_SEC     = 30,
    parameter int          NUM_LEDS     = 18,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          MIN_SPAWN_MS = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] busy_leds,
    output logic                led_request,
    output logic [4:0]          led_index,
    output logic                game_active,
    output logic                game_over,
    output logic [6:0]          time_left
);

    // Multiply before dividing so small bench clocks do not truncate to zero.
    localparam longint SPAWN_CYC     = longint'(CLK_HZ) * SPAWN_MS / 1000;
    localparam longint MIN_SPAWN_CYC = longint'(CLK_HZ) * MIN_SPAWN_MS / 1000;
    localparam int     SPN_W         = $clog2(SPAWN_CYC + 1);
    localparam int     SEC_W         = $clog2(CLK_HZ + 1);

    if (GAME_SEC < 1 || GAME_SEC > 127 || NUM_LEDS < 1 || NUM_LEDS > 32 ||
        SPAWN_CYC < 1 || MIN_SPAWN_MS > SPAWN_MS) begin : g_bad_param
        $error("mole_spawner: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, RUN_WAIT, PICK, ISSUE, OVER} state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [SPN_W-1:0] spawn_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic [4:0]       probe;
    logic [4:0]       probes;

    logic             running, sec_tick, game_end, spawn_last, probe_busy;
    logic [4:0]       seed_idx, probe_next;
    logic [31:0]      busy_ext;

`ifdef SPAWN_SPEEDUP_EN
    localparam logic [SPN_W-1:0] MIN_INT = SPN_W'(MIN_SPAWN_CYC);
    logic [SPN_W-1:0] interval, interval_dec;
    assign interval_dec = interval - (interval >> 4);
`else
    localparam logic [SPN_W-1:0] interval = SPN_W'(SPAWN_CYC);
`endif

    assign running    = (state == RUN_WAIT) || (state == PICK) || (state == ISSUE);
    assign sec_tick   = (sec_cnt == SEC_W'(CLK_HZ - 1));
    assign game_end   = running && sec_tick && (time_left == 7'd1);
    assign spawn_last = (spawn_cnt >= interval - SPN_W'(1));

    // Fold the 5-bit LFSR slice into range; identical to a single subtract for NUM_LEDS >= 16.
    assign seed_idx   = 5'(32'(lfsr[4:0]) % NUM_LEDS);
    assign busy_ext   = 32'(busy_leds);
    assign probe_busy = busy_ext[probe];
    assign probe_next = (probe == 5'(NUM_LEDS - 1)) ? 5'd0 : probe + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            spawn_cnt   <= '0;
            sec_cnt     <= '0;
            probe       <= '0;
            probes      <= '0;
            led_request <= 1'b0;
            led_index   <= '0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            time_left   <= '0;
`ifdef SPAWN_SPEEDUP_EN
            interval    <= SPN_W'(SPAWN_CYC);
`endif
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

            if (running) begin
                sec_cnt <= sec_tick ? '0 : sec_cnt + SEC_W'(1);
                if (sec_tick) begin
                    time_left <= time_left - 7'd1;
`ifdef SPAWN_SPEEDUP_EN
                    interval  <= (interval_dec < MIN_INT) ? MIN_INT : interval_dec;
`endif
                end
            end

            // Expiry wins over any pending spawn; led_index keeps its last value.
            if (game_end) begin
                state       <= OVER;
                led_request <= 1'b0;
                game_active <= 1'b0;
                game_over   <= 1'b1;
            end else begin
                case (state)
                    IDLE, OVER: begin
                        if (start) begin
                            state       <= RUN_WAIT;
                            time_left   <= 7'(GAME_SEC);
                            spawn_cnt   <= '0;
                            sec_cnt     <= '0;
                            game_active <= 1'b1;
                            game_over   <= 1'b0;
`ifdef SPAWN_SPEEDUP_EN
                            interval    <= SPN_W'(SPAWN_CYC);
`endif
                        end
                    end
                    RUN_WAIT: begin
                        if (spawn_last) begin
                            spawn_cnt <= '0;
                            probe     <= seed_idx;
                            probes    <= '0;
                            state     <= PICK;
                        end else begin
                            spawn_cnt <= spawn_cnt + SPN_W'(1);
                        end
                    end
                    PICK: begin
                        if (!probe_busy) begin
                            led_request <= 1'b1;
                            led_index   <= probe;
                            state       <= ISSUE;
                        end else if (probes == 5'(NUM_LEDS - 1)) begin
                            state <= RUN_WAIT;
                        end else begin
                            probe  <= probe_next;
                            probes <= probes + 5'd1;
                        end
                    end
                    ISSUE: begin
                        led_request <= 1'b0;
                        state       <= RUN_WAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized bench for mole_spawner: predicts spawn times/indices per game from the rules.
module tb_mole_spawner;
    localparam int CLK_HZ   = 100;
    localparam int SPAWN_MS = 100;
    localparam int GAME_SEC = 3;
    localparam int NL       = 18;
    localparam int SPAWN_CYC = CLK_HZ * SPAWN_MS / 1000;
    localparam int GAME_CYC  = GAME_SEC * CLK_HZ;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NL-1:0] busy_leds = '0;
    logic          led_request;
    logic [4:0]    led_index;
    logic          game_active;
    logic          game_over;
    logic [6:0]    time_left;

    int n_chk = 0;
    int n_err = 0;
    int ecount;
    int last_idx = 0;
    int qi;
    int req_e[$];
    int req_i[$];

    mole_spawner #(
        .CLK_HZ(CLK_HZ), .SPAWN_MS(SPAWN_MS), .GAME_SEC(GAME_SEC), .NUM_LEDS(NL),
        .LFSR_SEED(SEED), .MIN_SPAWN_MS(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy_leds(busy_leds),
        .led_request(led_request), .led_index(led_index), .game_active(game_active),
        .game_over(game_over), .time_left(time_left)
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ecount);
        end
    endtask

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v = SEED;
        for (int i = 0; i < n; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
    endfunction

    // Game started at edge a: list of (edge after which led_request is high, index).
    function automatic void predict(input int a, input logic [NL-1:0] busy);
        int g = a + GAME_CYC;
        int r = a;
        req_e.delete();
        req_i.delete();
        while (r < g) begin
            int e = r + SPAWN_CYC;
            int s, idx, found;
            if (e >= g) break;
            s = int'(lfsr_after(e - 1) & 16'h1F);
            idx = (s >= NL) ? s - NL : s;
            found = -1;
            for (int j = 0; j < NL; j++)
                if (found < 0 && !busy[(idx + j) % NL]) found = j;
            if (found >= 0) begin
                if (e + 1 + found >= g) break;
                req_e.push_back(e + 1 + found);
                req_i.push_back((idx + found) % NL);
                r = e + 2 + found;
            end else begin
                r = e + NL;
            end
        end
    endfunction

    task automatic step_chk(input int a);
        int k, tl;
        bit exp_req;
        @(posedge clk);
        #1;
        k = ecount - a;
        exp_req = (qi < req_e.size()) && (req_e[qi] == ecount);
        chk("led_request", int'(led_request), int'(exp_req));
        if (exp_req) begin
            last_idx = req_i[qi];
            qi++;
        end
        chk("led_index", int'(led_index), last_idx);
        tl = (k >= GAME_CYC) ? 0 : GAME_SEC - k / CLK_HZ;
        chk("time_left", int'(time_left), tl);
        chk("game_active", int'(game_active), int'(k < GAME_CYC));
        chk("game_over", int'(game_over), int'(k >= GAME_CYC));
    endtask

    task automatic start_game(input logic [NL-1:0] busy, output int a);
        busy_leds = busy;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ecount;
        predict(a, busy);
        qi = 0;
        chk("start_active", int'(game_active), 1);
        chk("start_time", int'(time_left), GAME_SEC);
        chk("start_over", int'(game_over), 0);
        chk("start_req", int'(led_request), 0);
    endtask

    task automatic run_game(input logic [NL-1:0] busy, input bit inject);
        int a;
        int inj_k = $urandom_range(20, GAME_CYC - 20);
        start_game(busy, a);
        for (int k = 1; k <= GAME_CYC + 20; k++) begin
            step_chk(a);
            start = inject && (k == inj_k);
        end
        start = 1'b0;
        chk("all_reqs", qi, req_e.size());
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_req", int'(led_request), 0);
            chk("idle_active", int'(game_active), 0);
            chk("idle_over", int'(game_over), 0);
            chk("idle_time", int'(time_left), 0);
            chk("idle_index", int'(led_index), 0);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_idx = 0;
    endtask

    task automatic reset_mid_pulse;
        int a;
        start_game('0, a);
        for (int i = 0; i < 4 * SPAWN_CYC && qi == 0; i++) step_chk(a);
        chk("pulse_reached", qi, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_req", int'(led_request), 0);
        chk("rst_active", int'(game_active), 0);
        chk("rst_time", int'(time_left), 0);
        chk("rst_index", int'(led_index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_idx = 0;
    endtask

    initial begin
        logic [NL-1:0] m;
        do_reset();
        idle_chk(50);
        run_game('0, 1'b1);
        m = '1;
        m[7] = 1'b0;
        run_game(m, 1'b0);
        run_game('1, 1'b0);
        run_game(NL'($urandom) & NL'($urandom), 1'b1);
        run_game(NL'($urandom) | NL'($urandom), 1'b0);
        reset_mid_pulse();
        idle_chk(10);
        run_game(NL'($urandom), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
